clock_display: RTL

CLOCK_DISPLAY -- requirements
Module: clock_display

---
 rtl/clock_display.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/clock_display.sv
// ---------------------------------------------------------------------------
// clock_display
//
// Turns an 18-bit binary time {hour, min, sec} into six active-low 7-segment
// digits. A new value is snapshotted when the input differs from the last
// converted value, or unconditionally once after reset. All three 6-bit
// fields are converted to BCD in parallel by a sequential shift-add-3 over
// six cycles. The decoded segments are then registered in one step, so the
// display never shows a partial result.
//
// Optional feature: define BLINK_EN to blank the display at a 50% duty
// cycle while mode == 2'b01 (time-set). Without BLINK_EN, mode is ignored
// and no blink counter exists.
//
// Ports
//   clk              in   single clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   clock[17:0]      in   {hour[17:12], min[11:6], sec[5:0]}
//   mode[1:0]        in   2'b01 time-set, any other code run
//   hex0..hex5[6:0]  out  active-low {g,f,e,d,c,b,a}; sec/min/hour ones,tens
//   busy             out  conversion in progress
//   done             out  one-cycle pulse when the hex outputs update
// ---------------------------------------------------------------------------
module clock_display #(
   parameter int BLINK_DIV = 12500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [17:0] clock,
   input  logic [1:0]  mode,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t      state_reg, state_next;
   logic [17:0] snap_reg;
   logic [17:0] last_reg;
   logic        first_reg;
   logic [2:0]  step_reg;
   logic        done_reg;
   logic [41:0] seg_reg;    // {hex5..hex0} as registered by DONE
   logic [41:0] seg_next;
   logic        load;
   logic        blank;

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'h40;
         4'd1:    enc = 7'h79;
         4'd2:    enc = 7'h24;
         4'd3:    enc = 7'h30;
         4'd4:    enc = 7'h19;
         4'd5:    enc = 7'h12;
         4'd6:    enc = 7'h02;
         4'd7:    enc = 7'h78;
         4'd8:    enc = 7'h00;
         4'd9:    enc = 7'h10;
         default: enc = 7'h7F;
      endcase
   endfunction

   assign load = (state_reg == IDLE) && (first_reg || (clock != last_reg));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (load) state_next = CONV;
         CONV:    if (step_reg == 3'd5) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_reg != IDLE);
   end

   // ---------------- control registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_reg  <= '0;
         last_reg  <= '0;
         first_reg <= 1'b1;
         step_reg  <= '0;
         done_reg  <= 1'b0;
         seg_reg   <= {6{7'h7F}};
      end else begin
         done_reg <= (state_reg == DONE);
         case (state_reg)
            IDLE: if (load) begin
               snap_reg  <= clock;
               first_reg <= 1'b0;
               step_reg  <= '0;
            end
            CONV: step_reg <= step_reg + 3'd1;
            DONE: begin
               last_reg <= snap_reg;
               seg_reg  <= seg_next;
            end
            default: ;
         endcase
      end
   end

   // ---------------- per-field double-dabble and decode ----------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_field
         // Hours (field 2) are valid up to 23, minutes and seconds up to 59.
         localparam logic [5:0] LIMIT = (gi == 2) ? 6'd23 : 6'd59;

         logic [7:0] bcd_reg;
         logic [5:0] bin_reg;
         logic [7:0] bcd_adj;

         always_comb begin
            bcd_adj = bcd_reg;
            if (bcd_reg[3:0] >= 4'd5) bcd_adj[3:0] = bcd_reg[3:0] + 4'd3;
            if (bcd_reg[7:4] >= 4'd5) bcd_adj[7:4] = bcd_reg[7:4] + 4'd3;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bcd_reg <= '0;
               bin_reg <= '0;
            end else if (load) begin
               bcd_reg <= '0;
               bin_reg <= clock[gi*6 +: 6];
            end else if (state_reg == CONV) begin
               {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
            end
         end

         // Range check uses the snapshot, not the live input.
         assign seg_next[gi*14 +: 14] = (snap_reg[gi*6 +: 6] > LIMIT) ?
                                        {7'h3F, 7'h3F} :
                                        {enc(bcd_reg[7:4]), enc(bcd_reg[3:0])};
      end
   endgenerate

   // ---------------- optional blink ----------------
`ifdef BLINK_EN
   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt_reg;
   logic          phase_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end else if (mode == 2'b01) begin
         if (cnt_reg == CW'(BLINK_DIV - 1)) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end else begin
         // Held at zero so digits reappear the cycle after set mode ends.
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end
   end

   assign blank = phase_reg;
`else
   logic unused_mode;
   assign unused_mode = ^mode;
   assign blank       = 1'b0;
`endif

   // Blanking sits after the segment register; conversion is unaffected.
   assign hex0 = blank ? 7'h7F : seg_reg[6:0];
   assign hex1 = blank ? 7'h7F : seg_reg[13:7];
   assign hex2 = blank ? 7'h7F : seg_reg[20:14];
   assign hex3 = blank ? 7'h7F : seg_reg[27:21];
   assign hex4 = blank ? 7'h7F : seg_reg[34:28];
   assign hex5 = blank ? 7'h7F : seg_reg[41:35];
   assign done = done_reg;

endmodule
